setup_packet_decoder: RTL and testbench
=======================================

// Module: setup_packet_decoder
// PURPOSE
//  Upstream stage of the trace/descriptor selector. Assembles the 8-byte SETUP stream from the
//  packet receiver into request fields: bmRequestType, bRequest, wValue, wIndex, wLength.
//  Presents bRequest and the select index to the trace stage and holds them until acknowledged.
//  Flags malformed packets (too short or too long) instead of forwarding them.
// PARAMETERS
//  SETUP_BYTES  8   bytes per SETUP packet (byte count index is 3 bits)
//  SEL_W        9   width of select output, taken from wValue[SEL_W-1:0]
// PORTS
//  clk            in   1   single clock, all logic on rising edge
//  reset_L        in   1   synchronous reset, active low
//  sop            in   1   start of SETUP data packet; next valid byte is byte 0
//  byte_in        in   8   received data byte, little-endian field order
//  byte_valid     in   1   byte_in valid this cycle
//  byte_ready     out  1   decoder accepts byte_in (transfer = byte_valid & byte_ready)
//  eop            in   1   end of packet, coincident with or after the last byte
//  bmRequestType  out  8   byte 0
//  bRequest       out  8   byte 1; feeds the trace stage
//  select         out  9   wValue[8:0]; feeds the trace stage select
//  wIndex         out  16  bytes 4..5
//  wLength        out  16  bytes 6..7
//  setup_valid    out  1   fields valid; level, held until setup_ack
//  setup_ack      in   1   downstream consumed the fields
//  setup_err      out  1   one-cycle pulse: malformed packet dropped
// BEHAVIOUR
//  Reset (reset_L=0 at a clock edge): state IDLE, byte count 0, byte_ready 0, setup_valid 0,
//   setup_err 0, all field outputs 0. Reset mid-packet discards the partial packet.
//  FSM:
//   IDLE     byte_ready=0. sop -> COLLECT, count=0.
//   COLLECT  byte_ready=1. On each transfer, write byte_in to shadow byte[count], count++.
//            eop with count(after this cycle)==8 -> HOLD.
//            eop with count<8 -> ERR.
//            A 9th byte transfer -> ERR.
//            sop while in COLLECT restarts the packet (count=0, shadow kept; overwritten).
//   HOLD     One cycle after entry, outputs load from shadow and setup_valid=1; byte_ready=0.
//            setup_ack -> IDLE, setup_valid=0 on the next cycle; outputs keep their last values.
//            sop in HOLD is ignored (byte_ready=0 back-pressures the receiver).
//   ERR      setup_err=1 for exactly one cycle -> IDLE; outputs and setup_valid are unchanged.
//  Latency: transfer of byte 7 with eop at cycle N -> setup_valid=1 at N+2.
//  Simultaneous events:
//   - Byte transfer and eop in the same cycle: the byte counts first, then eop is evaluated.
//   - setup_ack while setup_valid=0 is ignored.
//  Field assembly: wValue={byte3,byte2}; select=wValue[SEL_W-1:0]; wIndex={byte5,byte4};
//   wLength={byte7,byte6}. The count register saturates at 8; no wrap.
// STRUCTURE
//  Shared package: state encoding localparams (IDLE, COLLECT, HOLD, ERR), SETUP_BYTES,
//   and request codes REQ_GET_DESCRIPTOR=8'h06 and REQ_PARAM_READ=8'h86 (shared with the trace stage).
//  Sub-module setup_shift_reg: 8x8 shadow byte array with write enable and index; the FSM
//   lives in the top level.
// TESTING
//  1. Bytes 80 06 05 01 00 00 40 00 with eop on the last byte -> setup_valid at N+2;
//     bRequest=06, select=9'h105, wLength=0040, no setup_err.
//  2. eop after 5 bytes -> setup_err pulses once, setup_valid stays 0, state back to IDLE.
//  3. 9 bytes before eop -> setup_err on the 9th byte; a following good packet decodes correctly.
//  4. Hold setup_ack=0 for 10 cycles -> setup_valid and fields stable, byte_ready=0;
//     ack -> setup_valid=0 next cycle.
//  5. reset_L=0 after 4 bytes -> all outputs 0; next full packet C0 86 ... decodes
//     with bRequest=86.
//  6. byte_valid gaps (valid every third cycle) with sop mid-COLLECT -> restart,
//     and only the last 8 bytes are decoded.

Source files
------------

// File: rtl/setup_packet_decoder_pkg.sv
// Shared definitions for the SETUP decoder and the trace stage: sizes, state codes,
// request codes and the field-assembly helper.
package setup_packet_decoder_pkg;

  localparam int SETUP_BYTES = 8;
  localparam int SEL_W       = 9;
  localparam int IDX_W       = $clog2(SETUP_BYTES);
  localparam int CNT_W       = $clog2(SETUP_BYTES + 1);

  localparam logic [1:0] IDLE_ENC    = 2'd0;
  localparam logic [1:0] COLLECT_ENC = 2'd1;
  localparam logic [1:0] HOLD_ENC    = 2'd2;
  localparam logic [1:0] ERR_ENC     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE_ENC,
    ST_COLLECT = COLLECT_ENC,
    ST_HOLD    = HOLD_ENC,
    ST_ERR     = ERR_ENC
  } state_e;

  localparam logic [7:0] REQ_GET_DESCRIPTOR = 8'h06;
  localparam logic [7:0] REQ_PARAM_READ     = 8'h86;

  typedef logic [SETUP_BYTES-1:0][7:0] shadow_t;

  typedef struct packed {
    logic [7:0]       bm_request_type;
    logic [7:0]       b_request;
    logic [SEL_W-1:0] select;
    logic [15:0]      w_index;
    logic [15:0]      w_length;
  } setup_fields_t;

  // Multi-byte fields are little-endian on the wire; select is the low part of wValue.
  function automatic setup_fields_t decode_fields(input shadow_t b);
    setup_fields_t f;
    f.bm_request_type = b[0];
    f.b_request       = b[1];
    f.select          = SEL_W'({b[3], b[2]});
    f.w_index         = {b[5], b[4]};
    f.w_length        = {b[7], b[6]};
    return f;
  endfunction

endpackage

// File: rtl/setup_packet_decoder_if.sv
// Byte stream from the packet receiver plus the decoded request handed to the trace stage.
interface setup_packet_decoder_if;
  import setup_packet_decoder_pkg::*;

  logic             sop;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             eop;
  logic [7:0]       bmRequestType;
  logic [7:0]       bRequest;
  logic [SEL_W-1:0] select;
  logic [15:0]      wIndex;
  logic [15:0]      wLength;
  logic             setup_valid;
  logic             setup_ack;
  logic             setup_err;

  // Receiver / trace-stage side.
  modport master (
    output sop, byte_in, byte_valid, eop, setup_ack,
    input  byte_ready, bmRequestType, bRequest, select, wIndex, wLength,
           setup_valid, setup_err
  );

  // Decoder side.
  modport slave (
    input  sop, byte_in, byte_valid, eop, setup_ack,
    output byte_ready, bmRequestType, bRequest, select, wIndex, wLength,
           setup_valid, setup_err
  );

endinterface

// File: rtl/setup_shift_reg.sv
// Shadow store for one SETUP packet: eight bytes written by index as they arrive.
module setup_shift_reg
  import setup_packet_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [7:0]       i_data,
  output shadow_t          o_bytes
);

  shadow_t r_bytes;

  // NOTE: storage array has no reset; every byte is rewritten before a packet is accepted,
  // and leaving it unreset lets it map onto plain flops or RAM without a clear path.
  // Sequential state always uses non-blocking assignment.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_bytes[i_idx] <= i_data;
    end
  end

  assign o_bytes = r_bytes;

endmodule

// File: rtl/setup_packet_decoder.sv
// Assembles the 8-byte SETUP stream into request fields, holds them until acknowledged,
// and drops malformed (short or long) packets with a one-cycle error pulse.
module setup_packet_decoder
  import setup_packet_decoder_pkg::*;
(
  input logic                   clk,
  input logic                   reset_L,
  setup_packet_decoder_if.slave bus
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_base;
  logic             w_xfer;
  logic             w_we;
  logic             w_load;
  logic             w_ack;
  logic             r_setup_valid;
  setup_fields_t    r_fields;
  shadow_t          w_shadow;

  assign bus.byte_ready = (r_state == ST_COLLECT);
  assign bus.setup_err  = (r_state == ST_ERR);
  assign w_xfer         = bus.byte_valid & bus.byte_ready;

  setup_shift_reg u_shadow (
    .clk     (clk),
    .i_we    (w_we),
    .i_idx   (w_base[IDX_W-1:0]),
    .i_data  (bus.byte_in),
    .o_bytes (w_shadow)
  );

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_base      = r_count;
    w_we        = 1'b0;
    w_load      = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.sop) begin
          w_state_nxt = ST_COLLECT;
          w_count_nxt = '0;
        end
      end
      ST_COLLECT: begin
        // A restart rewinds the write index; the byte on this cycle, if any, is byte 0.
        if (bus.sop) begin
          w_base = '0;
        end
        w_count_nxt = w_base;
        if (w_xfer && (w_base == CNT_W'(SETUP_BYTES))) begin
          w_state_nxt = ST_ERR;
        end else begin
          if (w_xfer) begin
            w_we        = 1'b1;
            w_count_nxt = w_base + 1'b1;
          end
          // The byte of this cycle is counted before eop decides the packet length.
          if (bus.eop) begin
            w_state_nxt = (w_count_nxt == CNT_W'(SETUP_BYTES)) ? ST_HOLD : ST_ERR;
          end
        end
      end
      ST_HOLD: begin
        if (!r_setup_valid) begin
          w_load = 1'b1;
        end else if (bus.setup_ack) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ERR: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Fields change only on a load, so an error or an ack leaves the last request visible.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_count       <= '0;
      r_setup_valid <= 1'b0;
      r_fields      <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_load) begin
        r_fields      <= decode_fields(w_shadow);
        r_setup_valid <= 1'b1;
      end else if (w_ack) begin
        r_setup_valid <= 1'b0;
      end
    end
  end

  assign bus.bmRequestType = r_fields.bm_request_type;
  assign bus.bRequest      = r_fields.b_request;
  assign bus.select        = r_fields.select;
  assign bus.wIndex        = r_fields.w_index;
  assign bus.wLength       = r_fields.w_length;
  assign bus.setup_valid   = r_setup_valid;

endmodule

// File: tb/tb_setup_packet_decoder.sv
// Directed and randomized packets checked against a packet-level model of the decoder.
`timescale 1ns/1ps
module tb_setup_packet_decoder;
  import setup_packet_decoder_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic reset_L;

  setup_packet_decoder_if bus();

  setup_packet_decoder dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Values the field outputs should currently show (last accepted packet, or zero after reset).
  int m_bm, m_req, m_sel, m_idx, m_len;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a good packet is the last eight bytes after sop, little-endian fields.
  task automatic model_accept(input byte_q_t q);
    int o;
    o     = q.size() - 8;
    m_bm  = int'(q[o]);
    m_req = int'(q[o+1]);
    m_sel = (int'(q[o+3]) * 256 + int'(q[o+2])) % 512;
    m_idx = int'(q[o+5]) * 256 + int'(q[o+4]);
    m_len = int'(q[o+7]) * 256 + int'(q[o+6]);
  endtask

  task automatic check_fields(input string tag);
    check({tag, "_bm"},  32'(bus.bmRequestType), m_bm);
    check({tag, "_req"}, 32'(bus.bRequest),      m_req);
    check({tag, "_sel"}, 32'(bus.select),        m_sel);
    check({tag, "_idx"}, 32'(bus.wIndex),        m_idx);
    check({tag, "_len"}, 32'(bus.wLength),       m_len);
  endtask

  task automatic start_packet(input string tag);
    bus.sop = 1'b1;
    tick();
    bus.sop = 1'b0;
    check({tag, "_ready"}, 32'(bus.byte_ready), 1);
  endtask

  task automatic send_stream(input byte_q_t q, input int gap, input bit with_eop);
    for (int i = 0; i < q.size(); i++) begin
      repeat (gap) tick();
      bus.byte_in    = q[i];
      bus.byte_valid = 1'b1;
      bus.eop        = with_eop && (i == q.size() - 1);
      tick();
      bus.byte_valid = 1'b0;
      bus.eop        = 1'b0;
    end
  endtask

  // Entered one cycle after the final byte+eop edge; q holds everything sent since sop.
  task automatic expect_good(input string tag, input byte_q_t q, input int hold, input bit early_ack);
    check({tag, "_valid_n1"}, 32'(bus.setup_valid), 0);
    check({tag, "_err_n1"},   32'(bus.setup_err),   0);
    bus.setup_ack = early_ack;
    tick();
    bus.setup_ack = 1'b0;
    model_accept(q);
    check({tag, "_valid_n2"}, 32'(bus.setup_valid), 1);
    check({tag, "_ready_hold"}, 32'(bus.byte_ready), 0);
    check_fields(tag);
    for (int h = 0; h < hold; h++) begin
      bus.sop = (h == 1);
      tick();
      bus.sop = 1'b0;
      check({tag, "_valid_held"}, 32'(bus.setup_valid), 1);
      check({tag, "_ready_held"}, 32'(bus.byte_ready),  0);
      check({tag, "_req_held"},   32'(bus.bRequest),    m_req);
      check({tag, "_sel_held"},   32'(bus.select),      m_sel);
    end
    bus.setup_ack = 1'b1;
    tick();
    bus.setup_ack = 1'b0;
    check({tag, "_valid_acked"}, 32'(bus.setup_valid), 0);
    check_fields({tag, "_kept"});
    tick();
    check({tag, "_idle_ready"}, 32'(bus.byte_ready), 0);
  endtask

  // Entered one cycle after the edge that made the packet malformed.
  task automatic expect_err(input string tag);
    check({tag, "_err"},   32'(bus.setup_err),   1);
    check({tag, "_valid"}, 32'(bus.setup_valid), 0);
    check_fields({tag, "_unch"});
    tick();
    check({tag, "_err_once"}, 32'(bus.setup_err),  0);
    check({tag, "_idle"},     32'(bus.byte_ready), 0);
  endtask

  initial begin
    byte_q_t q;
    byte_q_t junk;
    int      len;
    int      gap;

    reset_L        = 1'b0;
    bus.sop        = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    bus.eop        = 1'b0;
    bus.setup_ack  = 1'b0;
    m_bm = 0; m_req = 0; m_sel = 0; m_idx = 0; m_len = 0;
    tick();
    tick();
    check("rst_valid", 32'(bus.setup_valid), 0);
    check("rst_ready", 32'(bus.byte_ready),  0);
    check("rst_err",   32'(bus.setup_err),   0);
    check_fields("rst");
    reset_L = 1'b1;

    // Ack with nothing pending is ignored.
    bus.setup_ack = 1'b1;
    tick();
    bus.setup_ack = 1'b0;
    check("idle_ack_valid", 32'(bus.setup_valid), 0);
    check("idle_ack_ready", 32'(bus.byte_ready),  0);

    // Standard GET_DESCRIPTOR request, held unacknowledged for 10 cycles.
    q = '{8'h80, 8'h06, 8'h05, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
    start_packet("t1");
    send_stream(q, 0, 1'b1);
    check("t1_valid_n1", 32'(bus.setup_valid), 0);
    tick();
    check("t1_breq_const",  32'(bus.bRequest), 32'(REQ_GET_DESCRIPTOR));
    check("t1_sel_const",   32'(bus.select),   32'h105);
    check("t1_wlen_const",  32'(bus.wLength),  32'h0040);
    check("t1_err_const",   32'(bus.setup_err), 0);
    model_accept(q);
    for (int h = 0; h < 10; h++) begin
      tick();
      check("t4_valid_held", 32'(bus.setup_valid), 1);
      check("t4_ready_held", 32'(bus.byte_ready),  0);
      check_fields("t4_held");
    end
    bus.setup_ack = 1'b1;
    tick();
    bus.setup_ack = 1'b0;
    check("t4_valid_acked", 32'(bus.setup_valid), 0);
    check_fields("t4_kept");

    // Short packet: eop after 5 bytes.
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    start_packet("t2");
    send_stream(q, 0, 1'b1);
    expect_err("t2");

    // Nine bytes with no eop, then a good packet with an ack during the load cycle.
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    start_packet("t3");
    send_stream(q, 0, 1'b0);
    expect_err("t3");
    q = '{8'hA1, 8'h86, 8'hFF, 8'hFF, 8'h34, 8'h12, 8'hCD, 8'hAB};
    start_packet("t3b");
    send_stream(q, 0, 1'b1);
    expect_good("t3b", q, 3, 1'b1);

    // Reset after four bytes discards everything.
    q = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
    start_packet("t5");
    send_stream(q, 0, 1'b0);
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
    m_bm = 0; m_req = 0; m_sel = 0; m_idx = 0; m_len = 0;
    check("t5_valid", 32'(bus.setup_valid), 0);
    check("t5_ready", 32'(bus.byte_ready),  0);
    check("t5_err",   32'(bus.setup_err),   0);
    check_fields("t5_rst");
    q = '{8'hC0, 8'h86};
    repeat (6) q.push_back(8'($urandom));
    start_packet("t5b");
    send_stream(q, 0, 1'b1);
    expect_good("t5b", q, 2, 1'b0);
    check("t5b_req_const", 32'(bus.bRequest), 32'(REQ_PARAM_READ));

    // Sparse bytes with a restart mid-packet: only the bytes after the second sop count.
    junk = '{};
    repeat (3 + $urandom_range(0, 2)) junk.push_back(8'($urandom));
    start_packet("t6");
    send_stream(junk, 2, 1'b0);
    tick();
    start_packet("t6_restart");
    q = '{};
    repeat (8) q.push_back(8'($urandom));
    send_stream(q, 2, 1'b1);
    expect_good("t6", q, 1, 1'b0);

    // Random lengths 4..9 and gaps; the model accepts exactly eight bytes before eop.
    for (int n = 0; n < 12; n++) begin
      len = (n % 3 == 0) ? 8 : int'($urandom_range(4, 9));
      gap = int'($urandom_range(0, 2));
      q   = '{};
      repeat (len) q.push_back(8'($urandom));
      start_packet("rnd");
      if (len == 9) begin
        send_stream(q, gap, 1'b0);
        expect_err("rnd_long");
      end else begin
        send_stream(q, gap, 1'b1);
        if (len == 8) expect_good("rnd_good", q, int'($urandom_range(0, 3)), 1'(n % 2));
        else          expect_err("rnd_short");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
